// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (signed/unsigned) with abort and zero-divisor handling.
// Result is {remainder, quotient}, registered and held until the request level drops.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] divisor_q;
    logic        neg_quot_q;
    logic        neg_rem_q;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        mag1     = (signed_div_i && opdata1_i[31]) ? 32'd0 - opdata1_i : opdata1_i;
        mag2     = (signed_div_i && opdata2_i[31]) ? 32'd0 - opdata2_i : opdata2_i;
        shifted  = {rem_q, quot_q[31]};
        diff     = shifted - {1'b0, divisor_q};
        quot_fix = neg_quot_q ? 32'd0 - quot_q : quot_q;
        rem_fix  = neg_rem_q ? 32'd0 - rem_q : rem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            rem_q      <= 32'd0;
            quot_q     <= 32'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_q <= StByZero;
                        end else begin
                            // Dividend sits in quot_q and is shifted out into rem_q step by step
                            quot_q     <= mag1;
                            divisor_q  <= mag2;
                            rem_q      <= 32'd0;
                            cnt_q      <= 5'd0;
                            neg_quot_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                            neg_rem_q  <= signed_div_i && opdata1_i[31];
                            state_q    <= StOn;
                        end
                    end
                end
                StByZero: begin
                    if (annul_i) begin
                        state_q <= StIdle;
                    end else begin
                        quot_q     <= 32'd0;
                        rem_q      <= 32'd0;
                        neg_quot_q <= 1'b0;
                        neg_rem_q  <= 1'b0;
                        state_q    <= StEnd;
                    end
                end
                StOn: begin
                    if (annul_i) begin
                        state_q <= StIdle;
                    end else begin
                        if (!diff[32]) begin
                            rem_q  <= diff[31:0];
                            quot_q <= {quot_q[30:0], 1'b1};
                        end else begin
                            rem_q  <= shifted[31:0];
                            quot_q <= {quot_q[30:0], 1'b0};
                        end
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= StEnd;
                        end
                    end
                end
                StEnd: begin
                    // First END cycle publishes the result; afterwards only start_i low leaves
                    if (!ready_o) begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                    end else if (!start_i) begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sd, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        if (b == 32'd0) return 64'd0;
        if (!sd) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    task automatic launch(input logic sd, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = sd;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
    endtask

    // Waits for ready (operands scrambled meanwhile), checks latency, hold and release.
    task automatic finish_div(input logic [63:0] exp, input int exp_lat, input string tag);
        int lat;
        lat = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = k;
                break;
            end
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result_o, exp);
        for (int k = 0; k < 3; k++) begin
            annul_i   = 1'b1;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            @(negedge clk);
            check({tag, " hold ready"}, 64'(ready_o), 64'd1);
            check({tag, " hold result"}, result_o, exp);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check({tag, " release ready"}, 64'(ready_o), 64'd0);
        check({tag, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        rst = 1'b0;

        launch(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
        finish_div({32'h0000_000F, 32'h0FFF_FFFF}, 33, "udiv max/16");

        launch(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        finish_div({32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "sdiv -7/2");

        launch(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
        finish_div({32'h0000_0001, 32'hFFFF_FFFD}, 33, "sdiv 7/-2");

        launch(1'b0, 32'h0000_1234, 32'h0000_0000);
        finish_div(64'd0, 2, "div by zero");

        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_div({32'h0000_0000, 32'h8000_0000}, 33, "sdiv overflow");

        // Abort at step 10: start and annul dropped together so no restart follows
        launch(1'b0, 32'd1000, 32'd3);
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("annul no ready", 64'(seen), 64'd0);
        launch(1'b0, 32'd100, 32'd7);
        finish_div({32'd2, 32'd14}, 33, "after annul 100/7");

        // annul_i beats start_i in IDLE
        launch(1'b0, 32'd50, 32'd5);
        annul_i = 1'b1;
        seen    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("idle annul wins", 64'(seen), 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        // Reset in END with start held: outputs clear at once, then a fresh run
        launch(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (34) @(negedge clk);
        check("pre-reset ready", 64'(ready_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset END ready", 64'(ready_o), 64'd0);
        check("async reset END result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        finish_div({32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "restart after END reset");

        // Reset at step 20 of 100/7 with start held through reset
        launch(1'b0, 32'd100, 32'd7);
        repeat (21) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset ON ready", 64'(ready_o), 64'd0);
        check("async reset ON result", result_o, 64'd0);
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        signed_div_i = 1'b0;
        rst = 1'b0;
        finish_div({32'd2, 32'd14}, 33, "restart after ON reset");

        for (int i = 0; i < 16; i++) begin
            sd = 1'($urandom);
            a  = $urandom;
            case ($urandom % 8)
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 20);
                3:       b = 32'd0 - $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            if (i == 0) a = 32'h8000_0000;
            launch(sd, a, b);
            finish_div(model(sd, a, b), (b == 32'd0) ? 2 : 33, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 opdata1_i  input  32  dividend; sampled with start_i.
REQ-006 opdata2_i  input  32  divisor; sampled with start_i.
REQ-007 start_i  input  1  request level from the ALU; held high until ready_o is seen.
REQ-008 annul_i  input  1  abort the current division.
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
REQ-010 ready_o  output  1  result_o valid; registered.

Function
REQ-011 The FSM SHALL have four states: IDLE, BYZERO, ON, END.
REQ-012 IDLE, start_i=1, annul_i=0, opdata2_i=0: SHALL go to BYZERO.
REQ-013 IDLE, start_i=1, annul_i=0, opdata2_i!=0: SHALL latch the operands and signed_div_i, clear the iteration counter, and go to ON.
REQ-014 Signed mode SHALL divide the operand magnitudes: two's-complement negate each operand whose bit 31 is set.
REQ-015 ON SHALL perform one restoring shift-subtract step per clock: exactly 32 steps, counter 0..31.
REQ-016 ON, after step 32: SHALL go to END.
REQ-017 On entry to END, result_o SHALL be loaded and ready_o set to 1.
REQ-018 Signed fix-up: negate the quotient if the dividend and divisor signs differ; negate the remainder if the dividend is negative.
REQ-019 Unsigned results SHALL need no fix-up.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wraps; no exception flag).
REQ-021 BYZERO: SHALL go to END next cycle with result_o = 64'h0.
REQ-022 Latency, valid divisor: start_i sampled at edge E0; ready_o SHALL be high after edge E33.
REQ-023 Latency, zero divisor: ready_o SHALL be high after edge E2.
REQ-024 END: SHALL hold result_o and ready_o stable while start_i=1.
REQ-025 END, start_i=0: SHALL go to IDLE, clearing ready_o to 0 and result_o to 0.
REQ-026 annul_i=1 in BYZERO or ON: SHALL go to IDLE next edge; ready_o stays 0 and no result is produced.
REQ-027 annul_i=1 with start_i=1 in IDLE: annul_i SHALL win; the block stays in IDLE.
REQ-028 annul_i in END: SHALL be ignored; only start_i=0 leaves END.
REQ-029 In BYZERO/ON/END, changes on opdata1_i, opdata2_i, signed_div_i and start_i re-assertion SHALL be ignored.
REQ-030 Back-to-back: a new start is accepted only from IDLE, so at least one cycle with start_i=0 SHALL separate two divisions.
REQ-031 No combinational path SHALL exist from any input to result_o or ready_o.

Reset
REQ-032 rst=1 SHALL, asynchronously: set the FSM to IDLE, result_o=64'h0, ready_o=0, clear the counter and operand registers.
REQ-033 rst asserted mid-division (ON or END) SHALL discard the operation; after release the block SHALL accept a fresh start_i.

Verification
REQ-034 Unsigned 0xFFFFFFFF / 0x00000010 -> result_o = {0x0000000F, 0x0FFFFFFF}; ready_o rises after E33 and holds until start_i drops.
REQ-035 Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; signed 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
REQ-036 Divisor 0 (opdata1_i=0x1234) -> ready_o high after E2 with result_o=0; start_i low -> IDLE next cycle.
REQ-037 Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; the operands are changed to garbage during ON and the result is unaffected.
REQ-038 annul_i pulsed at step 10 -> IDLE and ready_o never asserts; a following 100/7 unsigned -> {0x00000002, 0x0000000E}.
REQ-039 rst asserted at step 20, start_i kept high through reset -> outputs 0 immediately; after release a new division of 100/7 restarts with full 33-cycle latency.
